jtl_delay_array: RTL



---
 rtl/jtl_pkg.sv | 16 +
 rtl/jtl_delay_lane.sv | 61 ++++++
 rtl/jtl_delay_array.sv | 38 +++
 3 files changed

// File: rtl/jtl_pkg.sv
// Shared constants, the per-lane delay type and the delay clamp for the JTL delay array.
package jtl_pkg;
  localparam int CHANNELS_DEF  = 4;
  localparam int MAX_DELAY_DEF = 8;
  localparam int DELAY_W_DEF   = 4;
  localparam int CNT_W_DEF     = 16;

  typedef logic [DELAY_W_DEF-1:0] delay_t;

  // Out-of-range requests are silently pulled into 1..max_d.
  function automatic delay_t clamp_delay(input delay_t d, input int max_d);
    if (d == '0) return delay_t'(1);
    if (int'(d) > max_d) return delay_t'(max_d);
    return d;
  endfunction
endpackage

// File: rtl/jtl_delay_lane.sv
// One toggle-encoded pulse lane: edge detect, programmable delay line, output toggle,
// saturating emit counter and in-flight flag.
module jtl_delay_lane import jtl_pkg::*; #(
  parameter int MAX_DELAY     = MAX_DELAY_DEF,
  parameter int DELAY_W       = DELAY_W_DEF,
  parameter int DEFAULT_DELAY = 1,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pulse_in_i,
  input  logic [DELAY_W-1:0] cfg_delay_i,
  input  logic               cfg_load_i,
  output logic               out_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               busy_o
);
  logic                 in_q, out_q, busy_q;
  logic [DELAY_W-1:0]   dly_q, dly_d;
  logic [MAX_DELAY-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pulse, emit;

  always_comb begin
    pulse = pulse_in_i ^ in_q;
    dly_d = cfg_load_i ? cfg_delay_i : dly_q;
    emit  = 1'b0;
    for (int k = 0; k < MAX_DELAY; k++)
      if (k + 1 == int'(dly_q)) emit = sr_q[k];
    if (cfg_load_i) emit = 1'b0;
    // A load flushes everything in flight but keeps the pulse arriving this edge.
    sr_d    = cfg_load_i ? '0 : (sr_q << 1);
    sr_d[0] = pulse;
    // Drop bits past the tap so busy falls on the emitting edge.
    for (int k = 0; k < MAX_DELAY; k++)
      if (k >= int'(dly_d)) sr_d[k] = 1'b0;
    cnt_d = cnt_q;
    if (emit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    in_q <= pulse_in_i;
    if (rst) begin
      dly_q  <= DELAY_W'(DEFAULT_DELAY);
      sr_q   <= '0;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dly_q  <= dly_d;
      sr_q   <= sr_d;
      out_q  <= out_q ^ emit;
      busy_q <= |sr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_o  = out_q;
  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;
endmodule

// File: rtl/jtl_delay_array.sv
// CHANNELS independent toggle-encoded JTL delay lanes sharing one configuration strobe.
module jtl_delay_array import jtl_pkg::*; #(
  parameter int CHANNELS      = CHANNELS_DEF,
  parameter int MAX_DELAY     = MAX_DELAY_DEF,
  parameter int DELAY_W       = DELAY_W_DEF,
  parameter int DEFAULT_DELAY = 1,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         in,
  input  logic [CHANNELS*DELAY_W-1:0] delay_cfg,
  input  logic                        cfg_load,
  output logic [CHANNELS-1:0]         out,
  output logic [CHANNELS*CNT_W-1:0]   pulse_count,
  output logic [CHANNELS-1:0]         busy
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    delay_t cfg_c;
    assign cfg_c = clamp_delay(delay_t'(delay_cfg[i*DELAY_W +: DELAY_W]), MAX_DELAY);

    jtl_delay_lane #(
      .MAX_DELAY     (MAX_DELAY),
      .DELAY_W       (DELAY_W),
      .DEFAULT_DELAY (DEFAULT_DELAY),
      .CNT_W         (CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .pulse_in_i  (in[i]),
      .cfg_delay_i (DELAY_W'(cfg_c)),
      .cfg_load_i  (cfg_load),
      .out_o       (out[i]),
      .cnt_o       (pulse_count[i*CNT_W +: CNT_W]),
      .busy_o      (busy[i])
    );
  end
endmodule
